// File: rtl/debounced_mux_pkg.sv
// Shared types and helpers for the debounced channel multiplexer.
package debounced_mux_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_QUALIFY = 1'b1
    } dmux_state_e;

    // Selector width for a given channel count; never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounced_mux_mux_n.sv
// Combinational N-way channel selector; an out-of-range index yields zero.
module mux_n
    import debounced_mux_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 1,
    localparam int SEL_W   = sel_width(N_INPUTS)
) (
    input  logic [N_INPUTS*DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]           sel_i,
    output logic [DATA_W-1:0]          data_o
);

    // Pick the slice whose index matches the selector.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (int'(sel_i) == k) begin
                data_o = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/debounced_mux.sv
// Channel multiplexer whose selector must hold a new value for
// STABLE_CYCLES consecutive samples before the switch is committed.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no candidate; sel_in equals the committed channel or is invalid
// ST_QUALIFY | candidate latched, counting consecutive matching samples
module debounced_mux
    import debounced_mux_pkg::*;
#(
    parameter int N_INPUTS      = 4,
    parameter int DATA_W        = 1,
    parameter int STABLE_CYCLES = 4,
    parameter int RESET_SEL     = 0,
    localparam int SEL_W        = sel_width(N_INPUTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_INPUTS*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]           sel_in,
    output logic [DATA_W-1:0]          data_out,
    output logic [SEL_W-1:0]           sel_active,
    output logic                       change_pulse,
    output logic                       pending,
    output logic [7:0]                 change_count
);

    localparam logic [SEL_W-1:0] RESET_SEL_V = SEL_W'(RESET_SEL);
    localparam logic [7:0]       STABLE_V    = 8'(STABLE_CYCLES);

    dmux_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_active_q, sel_active_d;
    logic [SEL_W-1:0]  cand_q, cand_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        change_count_q, change_count_d;
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] mux_data;
    logic              pulse_q;
    logic              init_q;
    logic              commit;
    logic              sel_valid_new;

    // An out-of-range request behaves exactly like re-requesting the active channel.
    assign sel_valid_new = (int'(sel_in) < N_INPUTS) && (sel_in != sel_active_q);

    mux_n #(
        .N_INPUTS (N_INPUTS),
        .DATA_W   (DATA_W)
    ) u_mux (
        .data_i (data_in),
        .sel_i  (sel_active_q),
        .data_o (mux_data)
    );

    // State and datapath registers; init_q makes the first post-reset edge announce the selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sel_active_q   <= RESET_SEL_V;
            cand_q         <= RESET_SEL_V;
            count_q        <= 8'd0;
            change_count_q <= 8'd0;
            data_out_q     <= '0;
            pulse_q        <= 1'b0;
            init_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            sel_active_q   <= sel_active_d;
            cand_q         <= cand_d;
            count_q        <= count_d;
            change_count_q <= change_count_d;
            data_out_q     <= mux_data;
            pulse_q        <= commit | init_q;
            init_q         <= 1'b0;
        end
    end

    // Next-state logic: qualify a candidate, restart on a different request, abort otherwise.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        count_d = count_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid_new) begin
                    cand_d = sel_in;
                    if (STABLE_CYCLES == 1) begin
                        commit  = 1'b1;
                        count_d = 8'd0;
                    end else begin
                        count_d = 8'd1;
                        state_d = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                // The candidate can never equal sel_active, so a match is always valid-new.
                if (sel_in == cand_q) begin
                    if (count_q + 8'd1 == STABLE_V) begin
                        commit  = 1'b1;
                        count_d = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end else if (sel_valid_new) begin
                    cand_d  = sel_in;
                    count_d = 8'd1;
                end else begin
                    count_d = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                count_d = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
        sel_active_d   = commit ? cand_d : sel_active_q;
        change_count_d = commit ? change_count_q + 8'd1 : change_count_q;
    end

    // Output decode.
    always_comb begin
        pending = (state_q == ST_QUALIFY);
    end

    assign sel_active   = sel_active_q;
    assign data_out     = data_out_q;
    assign change_pulse = pulse_q;
    assign change_count = change_count_q;

endmodule

// File: tb/tb_debounced_mux.sv
// Randomized and directed bench comparing two configurations of
// debounced_mux against a streak-counting reference model.
module tb_debounced_mux;

    logic        clk;
    logic        rst;
    logic [1:0]  sel_in;
    logic [31:0] data_a;
    logic [23:0] data_b;

    logic [7:0]  dout_a, dout_b;
    logic [1:0]  act_a, act_b;
    logic        pulse_a, pulse_b, pend_a, pend_b;
    logic [7:0]  cnt_a, cnt_b;

    int n_tests;
    int n_fail;

    // A: 4 channels, 3-sample qualification, reset to 0.
    debounced_mux #(
        .N_INPUTS(4), .DATA_W(8), .STABLE_CYCLES(3), .RESET_SEL(0)
    ) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .sel_in(sel_in),
        .data_out(dout_a), .sel_active(act_a), .change_pulse(pulse_a),
        .pending(pend_a), .change_count(cnt_a)
    );

    // B: 3 channels so sel_in = 3 is out of range; 2-sample qualification, reset to 1.
    debounced_mux #(
        .N_INPUTS(3), .DATA_W(8), .STABLE_CYCLES(2), .RESET_SEL(1)
    ) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .sel_in(sel_in),
        .data_out(dout_b), .sel_active(act_b), .change_pulse(pulse_b),
        .pending(pend_b), .change_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a commit happens once the same valid-new request has been
    // seen on `stable` consecutive edges; anything else breaks the streak.
    typedef struct {
        int         active;
        int         run_val;
        int         run_len;
        bit         first;
        logic [7:0] dout;
        bit         pulse;
        logic [7:0] cnt;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_step(model_t m, int n, int stable, int rsel,
                                          bit r, int s, logic [31:0] data);
        model_t o;
        bit     did_commit;
        o = m;
        did_commit = 1'b0;
        if (r) begin
            o.active  = rsel;
            o.run_val = rsel;
            o.run_len = 0;
            o.first   = 1'b1;
            o.dout    = 8'h00;
            o.pulse   = 1'b0;
            o.cnt     = 8'h00;
            return o;
        end
        o.dout = 8'((data >> (m.active * 8)) & 32'hFF);
        if (s < n && s != m.active) begin
            if (m.run_len > 0 && s == m.run_val) o.run_len = m.run_len + 1;
            else begin
                o.run_val = s;
                o.run_len = 1;
            end
            if (o.run_len >= stable) begin
                did_commit = 1'b1;
                o.active   = o.run_val;
                o.run_len  = 0;
            end
        end else begin
            o.run_len = 0;
        end
        o.pulse = did_commit || m.first;
        o.first = 1'b0;
        if (did_commit) o.cnt = m.cnt + 8'd1;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    // One clock edge: advance both models with the pre-edge inputs, then compare.
    task automatic tick();
        bit          r;
        int          s;
        logic [31:0] da, db;
        r  = rst;
        s  = int'(sel_in);
        da = data_a;
        db = {8'h00, data_b};
        @(posedge clk);
        m_a = model_step(m_a, 4, 3, 0, r, s, da);
        m_b = model_step(m_b, 3, 2, 1, r, s, db);
        #1;
        chk("a_sel",   32'(act_a),   32'(m_a.active));
        chk("a_dout",  32'(dout_a),  32'(m_a.dout));
        chk("a_pulse", 32'(pulse_a), 32'(m_a.pulse));
        chk("a_pend",  32'(pend_a),  32'(m_a.run_len > 0));
        chk("a_cnt",   32'(cnt_a),   32'(m_a.cnt));
        chk("b_sel",   32'(act_b),   32'(m_b.active));
        chk("b_dout",  32'(dout_b),  32'(m_b.dout));
        chk("b_pulse", 32'(pulse_b), 32'(m_b.pulse));
        chk("b_pend",  32'(pend_b),  32'(m_b.run_len > 0));
        chk("b_cnt",   32'(cnt_b),   32'(m_b.cnt));
    endtask

    task automatic drive(input int s, input int cycles);
        sel_in = 2'(s);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        int pulses;
        int target;
        logic [7:0] cnt_start;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        sel_in  = 2'd0;
        data_a  = 32'hD3C2B1A0;
        data_b  = 24'hC2B1A0;
        m_a = '{default: 0};
        m_b = '{default: 0};
        #1;

        // Reset two cycles, then release: announce pulse, data follows.
        drive(0, 2);
        chk("rst_sel_a", 32'(act_a), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_pulse_a", 32'(pulse_a), 32'd1);
        chk("rel_dout_a", 32'(dout_a), 32'hA0);
        tick();
        chk("rel_pulse_off_a", 32'(pulse_a), 32'd0);

        // Held request to channel 2: two pending cycles, commit on the third edge.
        drive(2, 2);
        chk("hold_pend_a", 32'(pend_a), 32'd1);
        tick();
        chk("hold_commit_a", 32'(act_a), 32'd2);
        chk("hold_pulse_a", 32'(pulse_a), 32'd1);
        chk("hold_cnt_a", 32'(cnt_a), 32'd1);
        tick();
        chk("hold_dout_a", 32'(dout_a), 32'hC2);

        // Bouncing request: 0,1,0,0,0 with restart on every change.
        drive(0, 1);
        drive(1, 1);
        drive(0, 2);
        chk("bounce_nocommit_a", 32'(act_a), 32'd2);
        drive(0, 1);
        chk("bounce_commit_a", 32'(act_a), 32'd0);

        // Abort: 3,3 then back to the active channel.
        drive(3, 2);
        drive(0, 1);
        chk("abort_sel_a", 32'(act_a), 32'd0);
        chk("abort_pend_a", 32'(pend_a), 32'd0);
        chk("oor_pend_b", 32'(pend_b), 32'd0);
        drive(1, 4);

        // Reset while qualifying with count 2 discards the candidate.
        drive(2, 2);
        rst = 1'b1;
        tick();
        chk("rst_discard_a", 32'(act_a), 32'd0);
        rst = 1'b0;
        drive(0, 2);

        // 256 alternating commits: counter wraps back to its start value.
        pulses    = 0;
        cnt_start = cnt_a;
        for (int k = 0; k < 256; k++) begin
            target = (m_a.active == 1) ? 2 : 1;
            sel_in = 2'(target);
            for (int c = 0; c < 3; c++) begin
                tick();
                if (pulse_a) pulses++;
            end
        end
        tick();
        if (pulse_a) pulses++;
        chk("wrap_pulses_a", 32'(pulses), 32'd256);
        chk("wrap_cnt_a", 32'(cnt_a), 32'(cnt_start));

        // Random bouncing selector, occasional data changes and resets.
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) sel_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                data_a = $urandom;
                data_b = 24'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
